// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: accepts one AC snoop, looks up the tag, answers on CR,
// streams the line on CD when required, then issues the line-state update.
// Optional `define ACE_SNOOP_RESP_PERF_EN adds saturating hit/miss counters.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | ac_ready high, waiting for a snoop
// S_LOOKUP | tag lookup requested/granted, waiting for the result
// S_CR     | snoop response presented until accepted
// S_DATA   | line read beat by beat from the data array and sent on CD
// S_UPDATE | line-state update presented until accepted
module ace_snoop_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int CD_BEATS   = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        ac_valid_i,
  output logic                        ac_ready_o,
  input  logic [ADDR_WIDTH-1:0]       ac_addr_i,
  input  logic [3:0]                  ac_snoop_i,
  output logic                        cr_valid_o,
  input  logic                        cr_ready_i,
  output logic [4:0]                  cr_resp_o,
  output logic                        cd_valid_o,
  input  logic                        cd_ready_i,
  output logic [DATA_WIDTH-1:0]       cd_data_o,
  output logic                        cd_last_o,
  output logic [ADDR_WIDTH-1:0]       addr_o,
  output logic                        lu_req_o,
  input  logic                        lu_gnt_i,
  input  logic                        lu_rvalid_i,
  input  logic [2:0]                  lu_state_i,
  output logic                        dat_req_o,
  input  logic                        dat_gnt_i,
  output logic [$clog2(CD_BEATS)-1:0] dat_beat_o,
  input  logic                        dat_rvalid_i,
  input  logic [DATA_WIDTH-1:0]       dat_rdata_i,
  output logic                        upd_valid_o,
  input  logic                        upd_ready_i,
  output logic [1:0]                  upd_op_o
`ifdef ACE_SNOOP_RESP_PERF_EN
  ,
  output logic [31:0]                 hit_cnt_o,
  output logic [31:0]                 miss_cnt_o
`endif
);

  localparam int BEAT_W = $clog2(CD_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(CD_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_CR,
    S_DATA,
    S_UPDATE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [3:0]            snoop_q;
  logic                  lu_granted;
  logic [4:0]            resp_q, resp_d;
  logic [1:0]            upd_q, upd_d;
  logic [BEAT_W-1:0]     beat;
  logic                  dat_wait;
  logic                  cd_valid;
  logic [DATA_WIDTH-1:0] cd_data;
  logic                  cd_last;
  logic                  lu_accept;
  logic                  cd_fire;

  assign lu_accept = (state == S_LOOKUP) && lu_granted && lu_rvalid_i;
  assign cd_fire   = cd_valid && cd_ready_i;

  // Response decode; bit order {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
  always_comb begin
    logic hit, dirty, uniq;
    hit    = lu_state_i[2];
    dirty  = lu_state_i[1];
    uniq   = lu_state_i[0];
    resp_d = 5'b00000;
    upd_d  = 2'b00;
    case (snoop_q)
      4'b0000: if (hit) resp_d = {uniq, 1'b1, 1'b0, 1'b0, 1'b1};
      4'b0001, 4'b0010, 4'b0011: if (hit) begin
        resp_d = {uniq, 1'b1, dirty, 1'b0, 1'b1};
        upd_d  = 2'b10;
      end
      4'b0111: if (hit) begin
        resp_d = {uniq, 1'b0, dirty, 1'b0, 1'b1};
        upd_d  = 2'b01;
      end
      4'b1001: if (hit) begin
        resp_d = {uniq, 1'b0, dirty, 1'b0, dirty};
        upd_d  = 2'b01;
      end
      4'b1000: if (hit) begin
        resp_d = {uniq, 1'b1, dirty, 1'b0, dirty};
        upd_d  = dirty ? 2'b10 : 2'b00;
      end
      4'b1101: if (hit) begin
        resp_d = {uniq, 4'b0000};
        upd_d  = 2'b01;
      end
      default: resp_d = 5'b00010;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ac_ready_o  = 1'b0;
    lu_req_o    = 1'b0;
    cr_valid_o  = 1'b0;
    dat_req_o   = 1'b0;
    upd_valid_o = 1'b0;
    case (state)
      S_IDLE: begin
        ac_ready_o = 1'b1;
        if (ac_valid_i) state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        lu_req_o = !lu_granted;
        if (lu_accept) state_nxt = S_CR;
      end
      S_CR: begin
        cr_valid_o = 1'b1;
        if (cr_ready_i) begin
          if (resp_q[0])          state_nxt = S_DATA;
          else if (upd_q != 2'b00) state_nxt = S_UPDATE;
          else                     state_nxt = S_IDLE;
        end
      end
      S_DATA: begin
        // One read in flight at most, and none while a beat waits on CD.
        dat_req_o = !dat_wait && !cd_valid;
        if (cd_fire && beat == LAST_BEAT)
          state_nxt = (upd_q != 2'b00) ? S_UPDATE : S_IDLE;
      end
      S_UPDATE: begin
        upd_valid_o = 1'b1;
        if (upd_ready_i) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      snoop_q    <= '0;
      lu_granted <= 1'b0;
      resp_q     <= '0;
      upd_q      <= '0;
      beat       <= '0;
      dat_wait   <= 1'b0;
      cd_valid   <= 1'b0;
      cd_data    <= '0;
      cd_last    <= 1'b0;
    end else begin
      if (state == S_IDLE && ac_valid_i) begin
        addr_q  <= ac_addr_i;
        snoop_q <= ac_snoop_i;
      end
      if (lu_req_o && lu_gnt_i) lu_granted <= 1'b1;
      if (lu_accept) begin
        lu_granted <= 1'b0;
        resp_q     <= resp_d;
        upd_q      <= upd_d;
      end
      if (state == S_CR && cr_ready_i) beat <= '0;
      if (dat_req_o && dat_gnt_i) dat_wait <= 1'b1;
      if (dat_wait && dat_rvalid_i) begin
        dat_wait <= 1'b0;
        cd_valid <= 1'b1;
        cd_data  <= dat_rdata_i;
        cd_last  <= (beat == LAST_BEAT);
      end
      // The last beat's increment wraps the counter exactly as DATA is left.
      if (cd_fire) begin
        cd_valid <= 1'b0;
        cd_last  <= 1'b0;
        beat     <= beat + 1'b1;
      end
    end
  end

  assign addr_o     = addr_q;
  assign cr_resp_o  = resp_q;
  assign upd_op_o   = upd_q;
  assign dat_beat_o = beat;
  assign cd_valid_o = cd_valid;
  assign cd_data_o  = cd_data;
  assign cd_last_o  = cd_last;

`ifdef ACE_SNOOP_RESP_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (lu_accept) begin
      if (lu_state_i[2]) begin
        if (hit_cnt != 32'hFFFF_FFFF) hit_cnt <= hit_cnt + 32'd1;
      end else begin
        if (miss_cnt != 32'hFFFF_FFFF) miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt;
  assign miss_cnt_o = miss_cnt;
`endif

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Self-checking bench for ace_snoop_responder: table vectors, directed stall and
// mid-line reset sequences, then randomized snoops against a spec-level model.
module tb_ace_snoop_responder;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ac_valid, ac_ready;
  logic [AW-1:0] ac_addr;
  logic [3:0]    ac_snoop;
  logic          cr_valid, cr_ready;
  logic [4:0]    cr_resp;
  logic          cd_valid, cd_ready;
  logic [DW-1:0] cd_data;
  logic          cd_last;
  logic [AW-1:0] addr;
  logic          lu_req, lu_gnt, lu_rvalid;
  logic [2:0]    lu_state;
  logic          dat_req, dat_gnt;
  logic [1:0]    dat_beat;
  logic          dat_rvalid;
  logic [DW-1:0] dat_rdata;
  logic          upd_valid, upd_ready;
  logic [1:0]    upd_op;
`ifdef ACE_SNOOP_RESP_PERF_EN
  logic [31:0]   hit_cnt, miss_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ace_snoop_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CD_BEATS(NB)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ac_valid_i(ac_valid), .ac_ready_o(ac_ready), .ac_addr_i(ac_addr), .ac_snoop_i(ac_snoop),
    .cr_valid_o(cr_valid), .cr_ready_i(cr_ready), .cr_resp_o(cr_resp),
    .cd_valid_o(cd_valid), .cd_ready_i(cd_ready), .cd_data_o(cd_data), .cd_last_o(cd_last),
    .addr_o(addr),
    .lu_req_o(lu_req), .lu_gnt_i(lu_gnt), .lu_rvalid_i(lu_rvalid), .lu_state_i(lu_state),
    .dat_req_o(dat_req), .dat_gnt_i(dat_gnt), .dat_beat_o(dat_beat),
    .dat_rvalid_i(dat_rvalid), .dat_rdata_i(dat_rdata),
    .upd_valid_o(upd_valid), .upd_ready_i(upd_ready), .upd_op_o(upd_op)
`ifdef ACE_SNOOP_RESP_PERF_EN
    , .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
`endif
  );

  typedef struct {
    logic [3:0] snoop;
    logic [2:0] st;
    logic [4:0] resp;
    logic [1:0] upd;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(input logic [31:0] a, input int b);
    logic [3:0] bl;
    bl = b[3:0];
    return {a ^ 32'hDEAD_BEEF, 28'h0ABC_DEF, bl};
  endfunction

  // Reference: snoop meaning -> {resp, upd} from the response rules.
  function automatic logic [6:0] model(input logic [3:0] s, input logic [2:0] st);
    bit h, d, u, dt, sh, pd, known;
    logic [1:0] up;
    h = st[2]; d = st[1]; u = st[0];
    known = 1; dt = 0; sh = 0; pd = 0; up = 2'b00;
    case (s)
      4'd0:         begin dt = 1; sh = 1; end
      4'd1, 4'd2, 4'd3: begin dt = 1; sh = 1; pd = d; up = 2'b10; end
      4'd7:         begin dt = 1; pd = d; up = 2'b01; end
      4'd9:         begin dt = d; pd = d; up = 2'b01; end
      4'd8:         begin dt = d; pd = d; sh = 1; up = d ? 2'b10 : 2'b00; end
      4'd13:        up = 2'b01;
      default:      known = 0;
    endcase
    if (!known) return 7'b0001000;
    if (!h)     return 7'b0;
    return {u, sh, pd, 1'b0, dt, up};
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ac_ready"}, ac_ready, 1'b1);
    chk({tag, "_valids"}, {cr_valid, cd_valid, lu_req, dat_req, upd_valid}, 5'b0);
    chk({tag, "_resp_op_last"}, {cr_resp, upd_op, cd_last}, 8'b0);
    chk({tag, "_cd_data"}, cd_data, 64'b0);
    chk({tag, "_beat"}, dat_beat, 2'b0);
  endtask

  task automatic idle_inputs();
    ac_valid = 0; cr_ready = 0; cd_ready = 0; lu_gnt = 0; lu_rvalid = 0;
    dat_gnt = 0; dat_rvalid = 0; upd_ready = 0;
  endtask

  task automatic run_snoop(input logic [3:0] snp, input logic [2:0] st, input logic [4:0] er,
                           input logic [1:0] eu, input int stall_beat, input int abort_beat);
    logic [31:0] a;
    logic [63:0] held;
    logic [1:0]  pend_beat;
    int cyc, beats, crs, upds, lu_phase, lu_cnt, stall_cnt;
    bit dat_pend, done;
    a = $urandom;
    cyc = 0; beats = 0; crs = 0; upds = 0; lu_phase = 0; lu_cnt = 0; stall_cnt = 0;
    dat_pend = 0; done = 0; held = '0; pend_beat = '0;
    @(negedge clk);
    chk("ac_ready_idle", ac_ready, 1'b1);
    ac_valid = 1; ac_addr = a; ac_snoop = snp;
    @(negedge clk);
    ac_valid = 0; ac_addr = $urandom; ac_snoop = 4'($urandom);
    chk("addr_latched", addr, a);
    while (!done && cyc < 500) begin
      if (ac_ready && crs > 0) begin
        done = 1;
        break;
      end
      lu_rvalid = 0; lu_state = 3'($urandom); lu_gnt = 0;
      dat_rvalid = 0; dat_rdata = {$urandom, $urandom}; dat_gnt = 0;
      if (lu_phase == 1) begin
        if (lu_cnt == 0) begin lu_rvalid = 1; lu_state = st; lu_phase = 2; end
        else lu_cnt--;
      end
      if (lu_req) begin
        lu_gnt = ($urandom_range(0, 2) != 0);
        if (lu_gnt) begin lu_phase = 1; lu_cnt = $urandom_range(0, 2); end
      end
      if (dat_pend) begin
        dat_rvalid = 1; dat_rdata = pat(a, int'(pend_beat)); dat_pend = 0;
      end
      if (dat_req) begin
        chk("no_req_while_cd", cd_valid, 1'b0);
        chk("dat_beat", dat_beat, beats[1:0]);
        dat_gnt = ($urandom_range(0, 2) != 0);
        if (dat_gnt) begin dat_pend = 1; pend_beat = dat_beat; end
      end
      cd_ready = ($urandom_range(0, 3) != 0);
      if (cd_valid) begin
        if (abort_beat == beats) begin
          #1 rst_n = 0;
          idle_inputs();
          #1 check_reset_outputs("mid_data_rst");
          @(negedge clk);
          check_reset_outputs("mid_data_rst_held");
          rst_n = 1;
          return;
        end
        if (beats == stall_beat && stall_cnt < 10) begin
          cd_ready = 0;
          if (stall_cnt == 0) held = cd_data;
          else chk("stall_data_stable", cd_data, held);
          chk("stall_no_dat_req", dat_req, 1'b0);
          stall_cnt++;
        end
        if (cd_ready) begin
          chk("cd_data", cd_data, pat(a, beats));
          chk("cd_last", cd_last, beats == NB - 1);
          beats++;
        end
      end
      cr_ready = ($urandom_range(0, 2) != 0);
      if (cr_valid && cr_ready) begin
        chk("cr_resp", cr_resp, er);
        crs++;
      end
      upd_ready = ($urandom_range(0, 2) != 0);
      if (upd_valid && upd_ready) begin
        chk("upd_op", upd_op, eu);
        chk("upd_after_last_cd", beats, er[0] ? NB : 0);
        upds++;
      end
      @(negedge clk);
      cyc++;
    end
    idle_inputs();
    chk("finished_in_budget", done, 1'b1);
    chk("cr_count", crs, 1);
    chk("cd_beat_count", beats, er[0] ? NB : 0);
    chk("upd_count", upds, (eu != 2'b00) ? 1 : 0);
  endtask

  vec_t tbl[14];

  initial begin
    logic [6:0] m;
    logic [3:0] snp;
    logic [2:0] st;
    logic [3:0] known_snoops[8];
    tbl[0]  = '{4'b0001, 3'b111, 5'b11101, 2'b10};
    tbl[1]  = '{4'b0111, 3'b000, 5'b00000, 2'b00};
    tbl[2]  = '{4'b1101, 3'b100, 5'b00000, 2'b01};
    tbl[3]  = '{4'b0100, 3'b111, 5'b00010, 2'b00};
    tbl[4]  = '{4'b0000, 3'b101, 5'b11001, 2'b00};
    tbl[5]  = '{4'b0111, 3'b110, 5'b00101, 2'b01};
    tbl[6]  = '{4'b1001, 3'b100, 5'b00000, 2'b01};
    tbl[7]  = '{4'b1001, 3'b111, 5'b10101, 2'b01};
    tbl[8]  = '{4'b1000, 3'b100, 5'b01000, 2'b00};
    tbl[9]  = '{4'b1000, 3'b110, 5'b01101, 2'b10};
    tbl[10] = '{4'b0010, 3'b101, 5'b11001, 2'b10};
    tbl[11] = '{4'b0011, 3'b010, 5'b00000, 2'b00};
    tbl[12] = '{4'b1101, 3'b111, 5'b10000, 2'b01};
    tbl[13] = '{4'b1111, 3'b000, 5'b00010, 2'b00};
    known_snoops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd9, 4'd13};

    rst_n = 0;
    idle_inputs();
    ac_addr = '0; ac_snoop = '0; lu_state = '0; dat_rdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1;

    foreach (tbl[i]) run_snoop(tbl[i].snoop, tbl[i].st, tbl[i].resp, tbl[i].upd, -1, -1);

    run_snoop(4'b0001, 3'b111, 5'b11101, 2'b10, 2, -1);
    run_snoop(4'b0001, 3'b111, 5'b11101, 2'b10, -1, 1);
    run_snoop(4'b0111, 3'b111, 5'b10101, 2'b01, -1, -1);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) snp = 4'($urandom);
      else snp = known_snoops[$urandom_range(0, 7)];
      st = 3'($urandom);
      m = model(snp, st);
      run_snoop(snp, st, m[6:2], m[1:0], ($urandom_range(0, 3) == 0) ? 1 : -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
